// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: upstream control stage for the watch digit-counter chain.
//
// Conditions the raw start/clear buttons (2-flop sync, debounce, rising-edge
// detect, registered press pulse), runs the IDLE/RUN/PAUSE state machine and
// prescales clk into single-cycle count-enable ticks for the least-significant
// digit counter.
//
// Parameters:
//   CLK_DIV          clk cycles per count tick (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable synced samples to accept a level (>= 1)
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset         in   asynchronous, active-low reset
//   btn_start     in   raw start/pause button (asynchronous, active-high)
//   btn_clear     in   raw clear button (asynchronous, active-high)
//   start_resume  out  1-cycle count-enable tick to the digit counter
//   stop          out  level, 1 while in PAUSE
//   clear         out  1-cycle pulse, zeroes the counter chain
//   running       out  level, 1 while in RUN
//   state         out  00 IDLE, 01 RUN, 10 PAUSE
//
// Optional feature, enabled by defining STOPWATCH_LAP_EN:
//   btn_lap       in   raw lap button (same conditioning as the others)
//   lap_hold      out  toggled by lap presses in RUN; display freeze request
module stopwatch_ctrl #(
    parameter int unsigned CLK_DIV         = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
    output logic       lap_hold,
`endif
    output logic       start_resume,
    output logic       stop,
    output logic       clear,
    output logic       running,
    output logic [1:0] state
);

`ifdef STOPWATCH_LAP_EN
    localparam int unsigned NB = 3;
`else
    localparam int unsigned NB = 2;
`endif

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // Button path, one lane per button: bit 0 start, bit 1 clear, bit 2 lap
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_q;
    logic [NB-1:0] press;
    logic [DW-1:0] deb_cnt [NB];

`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {btn_lap, btn_clear, btn_start};
`else
    assign btn_raw = {btn_clear, btn_start};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            press <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int unsigned i = 0; i < NB; i++) begin
                // Any sample agreeing with the accepted level restarts the count
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    logic start_press;
    logic clear_press;
    assign start_press = press[0];
    assign clear_press = press[1];

    // FSM and prescaler
    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_d;
    logic          tick_d;
    logic          clear_d;

    always_comb begin
        state_d = state_q;
        presc_d = presc;
        tick_d  = 1'b0;
        clear_d = 1'b0;

        case (state_q)
            IDLE:    if (start_press) state_d = RUN;
            RUN:     if (start_press) state_d = PAUSE;
            PAUSE:   if (start_press) state_d = RUN;
            default: state_d = IDLE;
        endcase

        // Prescaler follows the current state, so a wrap coinciding with a
        // RUN->PAUSE press still ticks, and a PAUSE->RUN press resumes from
        // the held value on the following cycle.
        if (state_q == RUN) begin
            tick_d  = (presc == PRESC_LAST);
            presc_d = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end else if (state_q == IDLE) begin
            presc_d = '0;
        end

        // Clear overrides everything, including a simultaneous start press
        if (clear_press) begin
            state_d = IDLE;
            clear_d = 1'b1;
            presc_d = '0;
            tick_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            presc        <= '0;
            start_resume <= 1'b0;
            clear        <= 1'b0;
            stop         <= 1'b0;
            running      <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc        <= presc_d;
            start_resume <= tick_d;
            clear        <= clear_d;
            stop         <= (state_d == PAUSE);
            running      <= (state_d == RUN);
        end
    end

    assign state = state_q;

`ifdef STOPWATCH_LAP_EN
    logic lap_d;

    always_comb begin
        lap_d = lap_hold;
        if ((state_q == RUN) && press[2]) begin
            lap_d = ~lap_hold;
        end
        if (state_d == IDLE) begin
            lap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_hold <= 1'b0;
        end else begin
            lap_hold <= lap_d;
        end
    end
`endif

endmodule
